// File: rtl/sram_arbiter_if.sv
// Requester-side bus of the two-port SRAM arbiter.
// Both requesters share one bundle; per-requester fields are bit/slice indexed.
interface sram_arbiter_if #(
  parameter int SIZE       = 16,
  parameter int DATA_WIDTH = 4
);
  localparam int ADDR_WIDTH = $clog2(SIZE);

  logic [1:0]              req_valid;
  logic [1:0]              req_ready;
  logic [1:0]              req_rw;
  logic [2*ADDR_WIDTH-1:0] req_addr;
  logic [2*DATA_WIDTH-1:0] req_wdata;
  logic [1:0]              rsp_valid;
  logic [1:0]              rsp_ready;
  logic [DATA_WIDTH-1:0]   rsp_rdata;

  modport slave (
    input  req_valid, req_rw, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );

  modport master (
    output req_valid, req_rw, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/sram_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port SRAM with
// registered read data. Zero-fills the whole array after every reset.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// INIT      | post-reset zero-fill, one write per cycle, requests blocked
// IDLE      | arbitrate; writes complete here, reads move on
// READ_WAIT | SRAM read data arrives, captured into rsp_rdata at cycle end
// RESP      | rsp_valid to the read owner until it takes the data
module sram_arbiter #(
  parameter  int SIZE       = 16,
  parameter  int DATA_WIDTH = 4,
  localparam int ADDR_WIDTH = $clog2(SIZE)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sram_arbiter_if.slave         bus,
  output logic                  init_busy,
  output logic                  mem_en,
  output logic                  mem_rw,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {INIT, IDLE, READ_WAIT, RESP} state_t;

  state_t                state;
  state_t                state_nxt;
  logic [ADDR_WIDTH-1:0] fill_cnt;
  logic                  ptr;
  logic                  owner;
  logic                  rd_oor;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;

  logic                  grant;
  logic                  winner;
  logic                  win_rw;
  logic                  win_in_range;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [DATA_WIDTH-1:0] win_wdata;
  logic [1:0]            req_ready;
  logic [1:0]            rsp_valid;

  // Pick the winner: a lone requester always wins, a tie goes to the pointer.
  always_comb begin
    winner = 1'b0;
    if (bus.req_valid == 2'b11) begin
      winner = ptr;
    end else begin
      winner = bus.req_valid[1];
    end
    win_rw       = winner ? bus.req_rw[1] : bus.req_rw[0];
    win_addr     = winner ? bus.req_addr[2*ADDR_WIDTH-1 -: ADDR_WIDTH]
                          : bus.req_addr[ADDR_WIDTH-1:0];
    win_wdata    = winner ? bus.req_wdata[2*DATA_WIDTH-1 -: DATA_WIDTH]
                          : bus.req_wdata[DATA_WIDTH-1:0];
    // Out-of-range accesses are still accepted but never reach the SRAM.
    win_in_range = ({1'b0, win_addr} < (ADDR_WIDTH+1)'(SIZE));
  end

  // Next state, handshakes and SRAM controls.
  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    req_ready = 2'b00;
    rsp_valid = 2'b00;
    mem_en    = 1'b0;
    mem_rw    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      INIT: begin
        // Gated by rst_n so the SRAM sees no enable while reset is held.
        mem_en   = rst_n;
        mem_rw   = 1'b1;
        mem_addr = fill_cnt;
        if (fill_cnt == ADDR_WIDTH'(SIZE - 1)) begin
          state_nxt = IDLE;
        end
      end
      IDLE: begin
        if (|bus.req_valid) begin
          grant             = 1'b1;
          req_ready[winner] = 1'b1;
          mem_en            = win_in_range;
          mem_rw            = win_rw;
          mem_addr          = win_addr;
          mem_wdata         = win_wdata;
          if (!win_rw) begin
            state_nxt = READ_WAIT;
          end
        end
      end
      READ_WAIT: begin
        state_nxt = RESP;
      end
      RESP: begin
        rsp_valid[owner] = 1'b1;
        if (bus.rsp_ready[owner]) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = INIT;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= INIT;
    end else begin
      state <= state_nxt;
    end
  end

  // Zero-fill address counter, restarts from 0 on every reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_cnt <= '0;
    end else if (state == INIT) begin
      fill_cnt <= fill_cnt + 1'b1;
    end
  end

  // Round-robin pointer and read-owner bookkeeping, updated on each grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr    <= 1'b0;
      owner  <= 1'b0;
      rd_oor <= 1'b0;
    end else if (grant) begin
      ptr <= ~winner;
      if (!win_rw) begin
        owner  <= winner;
        rd_oor <= ~win_in_range;
      end
    end
  end

  // Read data capture; an out-of-range read returns zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_rdata_q <= '0;
    end else if (state == READ_WAIT) begin
      rsp_rdata_q <= rd_oor ? '0 : mem_rdata;
    end
  end

  assign init_busy     = (state == INIT);
  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: a SIZE=16 instance backed by a small SRAM
// model, and a SIZE=12 instance used for out-of-range accesses.
module tb_sram_arbiter;

  logic clk;
  logic rst_n;
  logic rst_n_b;

  sram_arbiter_if #(.SIZE(16), .DATA_WIDTH(4)) bus_a ();
  sram_arbiter_if #(.SIZE(12), .DATA_WIDTH(4)) bus_b ();

  logic       init_busy_a, mem_en_a, mem_rw_a;
  logic [3:0] mem_addr_a, mem_wdata_a, mem_rdata_a;
  logic       init_busy_b, mem_en_b, mem_rw_b;
  logic [3:0] mem_addr_b, mem_wdata_b, mem_rdata_b;

  logic [3:0] mem_a [16];
  logic       scrub;
  logic       mon_b;
  logic       seen_en_b;

  int n_checks;
  int n_fails;

  sram_arbiter #(.SIZE(16), .DATA_WIDTH(4)) u_dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus_a.slave),
    .init_busy (init_busy_a),
    .mem_en    (mem_en_a),
    .mem_rw    (mem_rw_a),
    .mem_addr  (mem_addr_a),
    .mem_wdata (mem_wdata_a),
    .mem_rdata (mem_rdata_a)
  );

  sram_arbiter #(.SIZE(12), .DATA_WIDTH(4)) u_dut_b (
    .clk       (clk),
    .rst_n     (rst_n_b),
    .bus       (bus_b.slave),
    .init_busy (init_busy_b),
    .mem_en    (mem_en_b),
    .mem_rw    (mem_rw_b),
    .mem_addr  (mem_addr_b),
    .mem_wdata (mem_wdata_b),
    .mem_rdata (mem_rdata_b)
  );

  // Non-zero constant read data so an ungated out-of-range read shows up.
  assign mem_rdata_b = 4'hF;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model with registered read data; scrub preloads a non-zero pattern.
  always @(posedge clk) begin
    if (scrub) begin
      for (int i = 0; i < 16; i++) mem_a[i] <= 4'h5;
    end else if (mem_en_a) begin
      if (mem_rw_a) mem_a[mem_addr_a] <= mem_wdata_a;
      else          mem_rdata_a       <= mem_a[mem_addr_a];
    end
  end

  // Records any SRAM enable on the SIZE=12 instance once its fill is done.
  always @(posedge clk or negedge rst_n_b) begin
    if (!rst_n_b)              seen_en_b <= 1'b0;
    else if (mon_b && mem_en_b) seen_en_b <= 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called 1 ns after reset release (or a step): checks all SIZE=16 fill writes.
  task automatic fill_checks_a();
    for (int i = 0; i < 16; i++) begin
      chk("fill_en",      32'(mem_en_a),        1);
      chk("fill_rw",      32'(mem_rw_a),        1);
      chk("fill_addr",    32'(mem_addr_a),      32'(i));
      chk("fill_wdata",   32'(mem_wdata_a),     0);
      chk("fill_busy",    32'(init_busy_a),     1);
      chk("fill_rsp_vld", 32'(bus_a.rsp_valid), 0);
      chk("fill_ready",   32'(bus_a.req_ready), 0);
      step();
      #1;
    end
    chk("fill_done_busy", 32'(init_busy_a), 0);
    chk("fill_done_en",   32'(mem_en_a),    0);
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    mon_b    = 1'b0;
    scrub    = 1'b1;
    rst_n    = 1'b1;
    rst_n_b  = 1'b1;
    bus_a.req_valid = 2'b00; bus_a.req_rw = 2'b00; bus_a.req_addr = '0;
    bus_a.req_wdata = '0;    bus_a.rsp_ready = 2'b00;
    bus_b.req_valid = 2'b00; bus_b.req_rw = 2'b00; bus_b.req_addr = '0;
    bus_b.req_wdata = '0;    bus_b.rsp_ready = 2'b00;
    #1;
    rst_n   = 1'b0;
    rst_n_b = 1'b0;
    step();
    step();
    #1;
    // Reset state.
    chk("rst_busy",    32'(init_busy_a),     1);
    chk("rst_ready",   32'(bus_a.req_ready), 0);
    chk("rst_rsp_vld", 32'(bus_a.rsp_valid), 0);
    chk("rst_rdata",   32'(bus_a.rsp_rdata), 0);
    chk("rst_mem_en",  32'(mem_en_a),        0);

    // Zero-fill of 16 words, init_busy falls after exactly 16 write cycles.
    step();
    rst_n = 1'b1;
    scrub = 1'b0;
    #1;
    fill_checks_a();

    // Req0 writes 0xA to addr 3, then req1 reads addr 3.
    bus_a.req_valid = 2'b01; bus_a.req_rw = 2'b01;
    bus_a.req_addr = {4'd0, 4'd3}; bus_a.req_wdata = {4'h0, 4'hA};
    #1;
    chk("wr_ready", 32'(bus_a.req_ready), 1);
    chk("wr_en",    32'(mem_en_a),        1);
    chk("wr_rw",    32'(mem_rw_a),        1);
    chk("wr_addr",  32'(mem_addr_a),      3);
    chk("wr_wdata", 32'(mem_wdata_a),     4'hA);
    step();
    bus_a.req_valid = 2'b10; bus_a.req_rw = 2'b00;
    bus_a.req_addr = {4'd3, 4'd0}; bus_a.req_wdata = '0; bus_a.rsp_ready = 2'b11;
    #1;
    chk("rd_ready", 32'(bus_a.req_ready), 2);
    chk("rd_en",    32'(mem_en_a),        1);
    chk("rd_rw",    32'(mem_rw_a),        0);
    chk("rd_addr",  32'(mem_addr_a),      3);
    step();
    bus_a.req_valid = 2'b00;
    #1;
    chk("rw_rsp_vld", 32'(bus_a.rsp_valid), 0);
    chk("rw_ready",   32'(bus_a.req_ready), 0);
    chk("rw_mem_en",  32'(mem_en_a),        0);
    step();
    #1;
    chk("rsp_vld", 32'(bus_a.rsp_valid), 2);
    chk("rsp_data", 32'(bus_a.rsp_rdata), 4'hA);
    step();
    #1;
    chk("rsp_done", 32'(bus_a.rsp_valid), 0);

    // Both requesters read continuously: grants alternate 0,1,0,1.
    bus_a.req_valid = 2'b11; bus_a.req_rw = 2'b00;
    bus_a.req_addr = {4'd7, 4'd3};
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("rr_grant", 32'(bus_a.req_ready), (k % 2 == 0) ? 1 : 2);
      step();
      #1;
      chk("rr_wait_ready", 32'(bus_a.req_ready), 0);
      step();
      #1;
      chk("rr_rsp_vld",  32'(bus_a.rsp_valid), (k % 2 == 0) ? 1 : 2);
      chk("rr_rsp_data", 32'(bus_a.rsp_rdata), (k % 2 == 0) ? 4'hA : 0);
      step();
    end

    // Lone requester wins whatever the pointer; writes grant back-to-back.
    bus_a.req_valid = 2'b10; bus_a.req_rw = 2'b10;
    bus_a.req_addr = {4'd5, 4'd0}; bus_a.req_wdata = {4'h6, 4'h0};
    #1;
    chk("solo1_ready", 32'(bus_a.req_ready), 2);
    chk("solo1_rw",    32'(mem_rw_a),        1);
    chk("solo1_addr",  32'(mem_addr_a),      5);
    chk("solo1_wdata", 32'(mem_wdata_a),     6);
    step();
    bus_a.req_valid = 2'b01; bus_a.req_rw = 2'b01;
    bus_a.req_addr = {4'd0, 4'd6}; bus_a.req_wdata = {4'h0, 4'h9};
    #1;
    chk("b2b_ready", 32'(bus_a.req_ready), 1);
    chk("b2b_addr",  32'(mem_addr_a),      6);
    step();
    bus_a.req_addr = {4'd0, 4'd8}; bus_a.req_wdata = {4'h0, 4'h3};
    #1;
    chk("solo0_ready", 32'(bus_a.req_ready), 1);
    chk("solo0_addr",  32'(mem_addr_a),      8);

    // Pointer now at req1: tie goes to req1; response stalled 5 cycles.
    step();
    bus_a.req_valid = 2'b11; bus_a.req_rw = 2'b00;
    bus_a.req_addr = {4'd5, 4'd6}; bus_a.req_wdata = '0; bus_a.rsp_ready = 2'b01;
    #1;
    chk("tie_ready", 32'(bus_a.req_ready), 2);
    chk("tie_addr",  32'(mem_addr_a),      5);
    chk("tie_rw",    32'(mem_rw_a),        0);
    step();
    #1;
    chk("stall_wait_ready", 32'(bus_a.req_ready), 0);
    for (int j = 0; j < 5; j++) begin
      step();
      #1;
      chk("stall_rsp_vld",  32'(bus_a.rsp_valid), 2);
      chk("stall_rsp_data", 32'(bus_a.rsp_rdata), 6);
      chk("stall_ready",    32'(bus_a.req_ready), 0);
    end
    bus_a.rsp_ready = 2'b11;
    bus_a.req_valid = 2'b01;
    step();
    #1;
    chk("post_stall_grant", 32'(bus_a.req_ready), 1);
    chk("post_stall_addr",  32'(mem_addr_a),      6);
    step();
    bus_a.req_valid = 2'b00;
    #1;
    chk("post_stall_wait", 32'(bus_a.rsp_valid), 0);
    step();
    #1;
    chk("post_stall_vld",  32'(bus_a.rsp_valid), 1);
    chk("post_stall_data", 32'(bus_a.rsp_rdata), 9);
    step();

    // Reset while a response is pending.
    bus_a.rsp_ready = 2'b00;
    bus_a.req_valid = 2'b01; bus_a.req_rw = 2'b00; bus_a.req_addr = {4'd0, 4'd3};
    #1;
    chk("prerst_grant", 32'(bus_a.req_ready), 1);
    step();
    bus_a.req_valid = 2'b00;
    step();
    #1;
    chk("prerst_vld",  32'(bus_a.rsp_valid), 1);
    chk("prerst_data", 32'(bus_a.rsp_rdata), 4'hA);
    #1;
    rst_n = 1'b0;
    bus_a.rsp_ready = 2'b11;
    #1;
    chk("midrst_vld",    32'(bus_a.rsp_valid), 0);
    chk("midrst_data",   32'(bus_a.rsp_rdata), 0);
    chk("midrst_busy",   32'(init_busy_a),     1);
    chk("midrst_mem_en", 32'(mem_en_a),        0);
    chk("midrst_ready",  32'(bus_a.req_ready), 0);
    step();
    step();
    rst_n = 1'b1;
    #1;
    fill_checks_a();
    bus_a.req_valid = 2'b10; bus_a.req_rw = 2'b00; bus_a.req_addr = {4'd3, 4'd0};
    #1;
    chk("refill_grant", 32'(bus_a.req_ready), 2);
    step();
    bus_a.req_valid = 2'b00;
    step();
    #1;
    chk("refill_vld",  32'(bus_a.rsp_valid), 2);
    chk("refill_data", 32'(bus_a.rsp_rdata), 0);
    step();

    // SIZE=12: 12-cycle fill, then out-of-range write and read at addr 14.
    rst_n_b = 1'b1;
    #1;
    for (int i = 0; i < 12; i++) begin
      chk("b_fill_busy", 32'(init_busy_b), 1);
      chk("b_fill_addr", 32'(mem_addr_b),  32'(i));
      chk("b_fill_en",   32'(mem_en_b),    1);
      step();
      #1;
    end
    chk("b_fill_done", 32'(init_busy_b), 0);
    mon_b = 1'b1;
    bus_b.req_valid = 2'b01; bus_b.req_rw = 2'b01;
    bus_b.req_addr = {4'd0, 4'd14}; bus_b.req_wdata = {4'h0, 4'h7};
    #1;
    chk("oor_wr_ready", 32'(bus_b.req_ready), 1);
    chk("oor_wr_en",    32'(mem_en_b),        0);
    step();
    bus_b.req_valid = 2'b10; bus_b.req_rw = 2'b00;
    bus_b.req_addr = {4'd14, 4'd0}; bus_b.req_wdata = '0; bus_b.rsp_ready = 2'b11;
    #1;
    chk("oor_rd_ready", 32'(bus_b.req_ready), 2);
    chk("oor_rd_en",    32'(mem_en_b),        0);
    step();
    bus_b.req_valid = 2'b00;
    #1;
    chk("oor_wait_en", 32'(mem_en_b), 0);
    step();
    #1;
    chk("oor_rsp_vld",  32'(bus_b.rsp_valid), 2);
    chk("oor_rsp_data", 32'(bus_b.rsp_rdata), 0);
    step();
    #1;
    chk("oor_rsp_done", 32'(bus_b.rsp_valid), 0);
    chk("oor_never_en", 32'(seen_en_b),       0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter SIZE, default 16, number of SRAM words.
REQ-002 SHALL have parameter DATA_WIDTH, default 4, SRAM word width.
REQ-003 SHALL have localparam ADDR_WIDTH, value $clog2(SIZE), address width.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port req_valid  input  2  per-requester access request (bit i = requester i).
REQ-007 SHALL have port req_ready  output  2  per-requester request accept.
REQ-008 SHALL have port req_rw  input  2  per-requester 1=write, 0=read.
REQ-009 SHALL have port req_addr  input  2*ADDR_WIDTH  packed addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-010 SHALL have port req_wdata  input  2*DATA_WIDTH  packed write data, same packing.
REQ-011 SHALL have port rsp_valid  output  2  read-data valid to owning requester.
REQ-012 SHALL have port rsp_ready  input  2  per-requester response accept.
REQ-013 SHALL have port rsp_rdata  output  DATA_WIDTH  read data, shared by both requesters.
REQ-014 SHALL have port init_busy  output  1  high while post-reset zero-fill runs.
REQ-015 SHALL have ports mem_en, mem_rw  output  1 each  SRAM enable / write select.
REQ-016 SHALL have ports mem_addr  output  ADDR_WIDTH and mem_wdata  output  DATA_WIDTH  SRAM address / write data.
REQ-017 SHALL have port mem_rdata  input  DATA_WIDTH  SRAM registered read data, valid one cycle after a read enable.

Function
REQ-018 SHALL implement states INIT, IDLE, READ_WAIT, RESP.
REQ-019 INIT: one write per cycle, mem_en=1, mem_rw=1, mem_wdata=0, mem_addr = fill counter 0..SIZE-1; init_busy=1; req_ready=0.
REQ-020 INIT SHALL transition to IDLE in the cycle after address SIZE-1 is written (exactly SIZE write cycles).
REQ-021 IDLE, no req_valid: mem_en=0, mem_rw=0, mem_addr=0, mem_wdata=0.
REQ-022 IDLE, one req_valid: that requester SHALL win regardless of the priority pointer.
REQ-023 IDLE, both req_valid: requester named by the round-robin pointer SHALL win.
REQ-024 After every grant, the pointer SHALL point to the non-winning requester.
REQ-025 Grant: req_ready[winner]=1 combinationally in the same cycle; mem_en/rw/addr/wdata driven from the winner's inputs in that cycle.
REQ-026 Write grant: state SHALL remain IDLE, no response; the next grant is possible the following cycle.
REQ-027 Read grant: owner SHALL be recorded; next state READ_WAIT.
REQ-028 READ_WAIT: mem_en=0, mem_rdata captured into rsp_rdata register at cycle end; next state RESP.
REQ-029 RESP: rsp_valid[owner]=1, other bit 0, rsp_rdata stable; hold until rsp_ready[owner]=1, then IDLE on that edge.
REQ-030 Read latency: request handshake at cycle T -> rsp_valid high from cycle T+2.
REQ-031 req_ready SHALL be 0 in INIT, READ_WAIT and RESP.
REQ-032 Out-of-range address (addr >= SIZE): request SHALL still be accepted; write with mem_en=0 (discarded); read with mem_en=0 and rsp_rdata=0.
REQ-033 Requesters SHALL hold req_* stable while valid && !ready; the block SHALL NOT be required to tolerate changes.
REQ-034 rsp_ready of a non-owner, or outside RESP, SHALL be ignored.

Reset
REQ-035 rst_n low SHALL asynchronously force INIT, fill counter 0, pointer 0, req_ready=0, rsp_valid=0, rsp_rdata=0, mem_en=0, init_busy=1.
REQ-036 Reset mid-operation (any state) SHALL drop any pending response and restart the full zero-fill after rst_n rises.

Verification
REQ-037 Release reset, SIZE=16 -> exactly 16 consecutive writes of 0 to addresses 0..15, init_busy falls on cycle 17.
REQ-038 Req0 write addr 3 data 0xA, then req1 read addr 3, rsp_ready=1 -> rsp_valid[1] two cycles after grant, rsp_rdata=0xA.
REQ-039 Both requesters hold read requests continuously, rsp_ready=1 -> grant order 0,1,0,1; no back-to-back grant to one side.
REQ-040 Read with rsp_ready held 0 for 5 cycles -> rsp_valid/rsp_rdata stable 5 cycles, req_ready=0 throughout, IDLE after rsp_ready=1.
REQ-041 SIZE=12, write addr 14 then read addr 14 -> both accepted, mem_en never asserted, rsp_rdata=0.
REQ-042 Assert rst_n low during RESP -> rsp_valid drops immediately, full zero-fill restarts, no stale response afterwards.
